// File: rtl/audio_pkg.sv
// Shared constants and helpers for the SID audio conditioning path.
package audio_pkg;

  localparam int AUDIO_W = 16;
  localparam int SAT_MAX = 2 ** (AUDIO_W - 1) - 1;
  localparam int SAT_MIN = -(2 ** (AUDIO_W - 1));

  typedef struct packed {
    logic signed [AUDIO_W-1:0] val;
    logic                      clip;
  } sat_t;

  // Phase increment giving OUT_HZ carries per second out of a 32-bit accumulator.
  function automatic logic [31:0] nco_step(input int clk_hz, input int out_hz);
    longint unsigned num;
    num = longint'(out_hz) << 32;
    return 32'(num / longint'(clk_hz));
  endfunction

  // Callers sign-extend any narrower value to 32 bits before saturating.
  function automatic sat_t sat16(input logic signed [31:0] x);
    sat_t r;
    if (x > SAT_MAX) begin
      r.val  = AUDIO_W'(SAT_MAX);
      r.clip = 1'b1;
    end else if (x < SAT_MIN) begin
      r.val  = AUDIO_W'(SAT_MIN);
      r.clip = 1'b1;
    end else begin
      r.val  = x[AUDIO_W-1:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_chan_filter.sv
// One audio channel: per-clock IIR low-pass, rounded capture on tick,
// optional DC blocker and saturation to 16 bits.
module audio_chan_filter
  import audio_pkg::*;
#(
  parameter int IN_W      = 18,
  parameter int LPF_SHIFT = 6,
  parameter int DCB_SHIFT = 10
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  input  logic signed [IN_W-1:0]    smp_i,
  input  logic                      tick_i,
  input  logic                      stc_i,
  input  logic                      dc_en_i,
  output logic signed [AUDIO_W-1:0] smp_o,
  output logic                      clip_o
);

  localparam int YW = IN_W + LPF_SHIFT;
  localparam int EW = IN_W + DCB_SHIFT;
  localparam logic signed [YW+1:0] LPF_RND = {{(YW+1){1'b0}}, 1'b1} << (LPF_SHIFT - 1);

  logic signed [YW-1:0]   y_q, y_d;
  logic signed [IN_W-1:0] s_q, s_d;
  logic signed [EW-1:0]   e_q, e_d;
  logic signed [YW+1:0]   x_w, y_w, lpf_err, lpf_step, y_rnd;
  logic signed [EW+1:0]   s_w, e_w, e_err, e_step;
  logic signed [IN_W-1:0] e_hi;
  logic signed [IN_W:0]   d;
  logic signed [31:0]     d_ext;
  sat_t                   sat;
  logic                   unused_bits;

  // Two guard bits keep X - y + round from ever wrapping.
  assign x_w      = {{(LPF_SHIFT+2){smp_i[IN_W-1]}}, smp_i} << LPF_SHIFT;
  assign y_w      = {{2{y_q[YW-1]}}, y_q};
  assign lpf_err  = x_w - y_w + LPF_RND;
  assign lpf_step = lpf_err >>> LPF_SHIFT;
  assign y_d      = y_q + lpf_step[YW-1:0];

  assign y_rnd    = y_w + LPF_RND;
  assign s_d      = y_rnd[LPF_SHIFT +: IN_W];

  // Estimate keeps tracking with the blocker bypassed so enabling it is seamless.
  assign s_w      = {{2{s_q[IN_W-1]}}, s_q, {DCB_SHIFT{1'b0}}};
  assign e_w      = {{2{e_q[EW-1]}}, e_q};
  assign e_err    = s_w - e_w;
  assign e_step   = e_err >>> DCB_SHIFT;
  assign e_d      = e_q + e_step[EW-1:0];
  assign e_hi     = e_q[EW-1:DCB_SHIFT];

  assign d        = dc_en_i ? {s_q[IN_W-1], s_q} - {e_hi[IN_W-1], e_hi}
                            : {s_q[IN_W-1], s_q};
  assign d_ext    = {{(31-IN_W){d[IN_W]}}, d};
  assign sat      = sat16(d_ext >>> (IN_W - AUDIO_W));
  assign smp_o    = sat.val;
  assign clip_o   = sat.clip;

  assign unused_bits = ^{lpf_step[YW+1:YW], y_rnd[YW+1:YW], y_rnd[LPF_SHIFT-1:0],
                         e_step[EW+1:EW]};

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      y_q <= '0;
      s_q <= '0;
      e_q <= '0;
    end else begin
      y_q <= y_d;
      if (tick_i) s_q <= s_d;
      if (stc_i)  e_q <= e_d;
    end
  end

endmodule

// File: rtl/audio_resampler.sv
// SID audio to 48 kHz: NCO decimation strobe, per-channel filtering and
// registered 16-bit outputs for the HDMI audio path.
module audio_resampler
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = 31500000,
  parameter int OUT_HZ    = 48000,
  parameter int IN_W      = 18,
  parameter int LPF_SHIFT = 6,
  parameter int DCB_SHIFT = 10
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic signed [IN_W-1:0]    in_l,
  input  logic signed [IN_W-1:0]    in_r,
  input  logic                      dc_en,
  output logic signed [AUDIO_W-1:0] out_l,
  output logic signed [AUDIO_W-1:0] out_r,
  output logic                      out_strobe,
  output logic                      clipped
);

  localparam int          NUM_CH = 2;
  localparam int          STAGES = 2;
  localparam logic [31:0] STEP   = nco_step(CLK_HZ, OUT_HZ);

  logic [31:0]                     phase_q, phase_d;
  logic                            tick;
  logic [STAGES:1]                 vld_q;
  logic [STAGES:0]                 vld_pipe;
  logic [NUM_CH-1:0][IN_W-1:0]     ch_in;
  logic [NUM_CH-1:0][AUDIO_W-1:0]  ch_smp, out_q;
  logic [NUM_CH-1:0]               ch_clip;
  logic                            clip_q;

  assign {tick, phase_d} = {1'b0, phase_q} + {1'b0, STEP};
  // [0] tick/capture, [1] DC blocker + output load, [2] strobe visible.
  assign vld_pipe = {vld_q, tick};
  assign ch_in    = {in_r, in_l};

  audio_chan_filter #(
    .IN_W      (IN_W),
    .LPF_SHIFT (LPF_SHIFT),
    .DCB_SHIFT (DCB_SHIFT)
  ) u_chan [NUM_CH-1:0] (
    .gclk    (clk),
    .grst_n  (resetn),
    .smp_i   (ch_in),
    .tick_i  (tick),
    .stc_i   (vld_pipe[1]),
    .dc_en_i (dc_en),
    .smp_o   (ch_smp),
    .clip_o  (ch_clip)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q <= '0;
      vld_q   <= '0;
      out_q   <= '0;
      clip_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      vld_q   <= vld_pipe[STAGES-1:0];
      if (vld_pipe[1]) begin
        out_q  <= ch_smp;
        clip_q <= |ch_clip;
      end
    end
  end

  assign out_l      = out_q[0];
  assign out_r      = out_q[1];
  assign out_strobe = vld_pipe[STAGES];
  assign clipped    = clip_q;

endmodule
